// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the memory port arbiter: FSM state encodings,
//   the read-data value returned on an aborted access, and helpers that
//   size the burst and timeout counters from their parameters.
//   No ports.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FETCH = 2'd2
  } arb_state_e;

  localparam logic [31:0] RDATA_ERR = 32'h0;

  // Width needed to hold the values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int burst_cnt_w(input int burst_limit);
    return cnt_width(burst_limit);
  endfunction

  function automatic int timeout_cnt_w(input int timeout_cycles);
    return cnt_width(timeout_cycles);
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer
//   Counts cycles spent waiting on mem_ack for the current transaction and
//   flags the cycle in which the wait reaches MAX_CYCLES. Only instantiated
//   when MEM_ARB_TIMEOUT_EN is defined.
// Ports
//   clk        in  clock
//   reset      in  synchronous active-high reset
//   clear_i    in  restart the count (a new transaction is being granted)
//   enable_i   in  a transaction is waiting this cycle without mem_ack
//   expired_o  out this waiting cycle is the MAX_CYCLES-th one
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int MAX_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int TW = timeout_cnt_w(MAX_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(MAX_CYCLES - 1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // cnt_q holds the number of waiting cycles already elapsed.
  assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory port between instruction fetch (IF) and the
//   data stage (MEM). Data has fixed priority, except that after BURST_LIMIT
//   consecutive data grants with a fetch pending, the fetch wins one grant.
//   Each access is one req/ack transaction; the requester sees a one-cycle
//   *_ready pulse the cycle after mem_ack. stall is the only combinational
//   output.
//   Optional feature: define MEM_ARB_TIMEOUT_EN to abort a transaction after
//   TIMEOUT_CYCLES cycles without mem_ack (pulses *_ready with zero data and
//   bus_err). Without it the FSM waits indefinitely and bus_err is 0.
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   if_req/if_addr               fetch request, held until if_ready
//   if_rdata/if_ready            fetch result, one-cycle ready pulse
//   d_req/d_we/d_addr/d_wdata    data request, held until d_ready
//   d_rdata/d_ready              load data (0 for stores), one-cycle pulse
//   mem_req/mem_we/mem_addr/mem_wdata   memory transaction outputs
//   mem_rdata/mem_ack            memory response
//   stall                        pipeline stall while any requester waits
//   bus_err                      one-cycle pulse on timeout abort
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BURST_LIMIT    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        bus_err
);

  localparam int BW = burst_cnt_w(BURST_LIMIT);
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LIMIT);

  arb_state_e  state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_ready_q, if_ready_d;
  logic        d_ready_q, d_ready_d;

  logic busy, ready_pulse, burst_block, grant_data, grant_fetch, timeout;

  assign busy        = (state_q != ST_IDLE);
  // The requester still holds req during its ready cycle; granting then
  // would replay the access.
  assign ready_pulse = if_ready_q | d_ready_q;
  assign burst_block = (burst_q == BURST_MAX) && if_req;
  assign grant_data  = !busy && !ready_pulse && d_req && !burst_block;
  assign grant_fetch = !busy && !ready_pulse && if_req && !grant_data;

`ifdef MEM_ARB_TIMEOUT_EN
  logic bus_err_q;

  mem_arb_timer #(
    .MAX_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (grant_data | grant_fetch),
    .enable_i (busy & ~mem_ack),
    .expired_o(timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) bus_err_q <= 1'b0;
    else       bus_err_q <= timeout;
  end

  assign bus_err = bus_err_q;
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_data)       state_d = ST_DATA;
        else if (grant_fetch) state_d = ST_FETCH;
      end
      ST_DATA, ST_FETCH: begin
        if (mem_ack || timeout) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    burst_d     = burst_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;

    if (grant_data) begin
      mem_req_d   = 1'b1;
      mem_we_d    = d_we;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
      if (!if_req)                 burst_d = '0;
      else if (burst_q != BURST_MAX) burst_d = burst_q + 1'b1;
    end else if (grant_fetch) begin
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = if_addr;
      burst_d    = '0;
    end

    if (busy && (mem_ack || timeout)) begin
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
      if (state_q == ST_DATA) begin
        d_ready_d = 1'b1;
        d_rdata_d = (timeout || mem_we_q) ? RDATA_ERR : mem_rdata;
      end else begin
        if_ready_d = 1'b1;
        if_rdata_d = timeout ? RDATA_ERR : mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      burst_q     <= burst_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign stall     = (d_req & ~d_ready_q) | (if_req & ~if_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Request drivers push the expected
// response (data, cycle of the ready pulse, bus_err) into per-port queues;
// a monitor pops and compares whenever a ready pulse appears.
module tb_mem_port_arbiter;

  localparam int TB_BURST   = 4;
  localparam int TB_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_ready;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        stall, bus_err;

  mem_port_arbiter #(
    .BURST_LIMIT   (TB_BURST),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .stall    (stall),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    int          cyc;
    logic        err;
  } exp_t;

  exp_t q_d[$];
  exp_t q_if[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: acks after wait_st waiting cycles; loads return rdv(addr).
  int wait_st = 0;
  bit no_ack  = 1'b0;

  function automatic logic [31:0] rdv(input logic [31:0] a);
    return (a == 32'h100) ? 32'hCAFE0001 : (a ^ 32'hA5A50000);
  endfunction

  initial begin
    int mcnt;
    mcnt      = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h5555AAAA;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req && !no_ack) begin
        if (mcnt == wait_st) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_we ? 32'hDEADBEEF : rdv(mem_addr);
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 32'h5555AAAA;
          mcnt++;
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h5555AAAA;
        mcnt      = 0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (d_ready) begin
        if (q_d.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_ready_unexpected: got d_ready=1 at cycle %0d, expected no pulse", cyc);
        end else begin
          e = q_d.pop_front();
          chk("d_rdata", d_rdata, e.rdata);
          chk("d_ready_cycle", 32'(cyc), 32'(e.cyc));
          chk("d_bus_err", {31'b0, bus_err}, {31'b0, e.err});
        end
      end
      if (if_ready) begin
        if (q_if.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_ready_unexpected: got if_ready=1 at cycle %0d, expected no pulse", cyc);
        end else begin
          e = q_if.pop_front();
          chk("if_rdata", if_rdata, e.rdata);
          chk("if_ready_cycle", 32'(cyc), 32'(e.cyc));
          chk("if_bus_err", {31'b0, bus_err}, {31'b0, e.err});
        end
      end
      if (bus_err && !d_ready && !if_ready) begin
        checks++; errors++;
        $display("FAIL bus_err_alone: got bus_err=1 without ready at cycle %0d, expected 0", cyc);
      end
    end
  end

  task automatic data_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input int lat, input bit keep,
                          input logic err);
    int t0;
    bit seen;
    exp_t e;
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    t0      = cyc;
    e.rdata = exp_rd;
    e.cyc   = t0 + lat;
    e.err   = err;
    q_d.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (d_ready) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL d_wait_timeout: got no d_ready within 100 cycles, expected one at cycle %0d", t0 + lat);
    end
    if (!keep) d_req = 1'b0;
  endtask

  task automatic fetch_req(input logic [31:0] addr, input logic [31:0] exp_rd, input int lat);
    int t0;
    bit seen;
    exp_t e;
    if_req  = 1'b1;
    if_addr = addr;
    t0      = cyc;
    e.rdata = exp_rd;
    e.cyc   = t0 + lat;
    e.err   = 1'b0;
    q_if.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (if_ready) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL if_wait_timeout: got no if_ready within 100 cycles, expected one at cycle %0d", t0 + lat);
    end
    if_req = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"},   {31'b0, mem_req},  32'h0);
    chk({tag, "_mem_we"},    {31'b0, mem_we},   32'h0);
    chk({tag, "_mem_addr"},  mem_addr,          32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata,         32'h0);
    chk({tag, "_if_ready"},  {31'b0, if_ready}, 32'h0);
    chk({tag, "_d_ready"},   {31'b0, d_ready},  32'h0);
    chk({tag, "_if_rdata"},  if_rdata,          32'h0);
    chk({tag, "_d_rdata"},   d_rdata,           32'h0);
    chk({tag, "_bus_err"},   {31'b0, bus_err},  32'h0);
    chk({tag, "_stall"},     {31'b0, stall},    32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: single load, zero wait states
    fork
      data_req(1'b0, 32'h100, 32'h0, 32'hCAFE0001, 2, 1'b0, 1'b0);
      begin
        #1;
        chk("t1_stall_c0", {31'b0, stall}, 32'h1);
        @(posedge clk); #1;
        chk("t1_stall_c1",   {31'b0, stall},   32'h1);
        chk("t1_mem_req_c1", {31'b0, mem_req}, 32'h1);
        chk("t1_mem_addr",   mem_addr,          32'h100);
        chk("t1_mem_we",     {31'b0, mem_we},  32'h0);
        @(posedge clk); #1;
        chk("t1_stall_c2",   {31'b0, stall},   32'h0);
        chk("t1_mem_req_c2", {31'b0, mem_req}, 32'h0);
      end
    join
    @(posedge clk); #1;

    // 2: store with 3 wait states
    wait_st = 3;
    fork
      data_req(1'b1, 32'h40, 32'h12345678, 32'h0, 5, 1'b0, 1'b0);
      begin
        for (int k = 1; k <= 4; k++) begin
          @(posedge clk); #1;
          chk("t2_mem_req",   {31'b0, mem_req}, 32'h1);
          chk("t2_mem_we",    {31'b0, mem_we},  32'h1);
          chk("t2_mem_addr",  mem_addr,          32'h40);
          chk("t2_mem_wdata", mem_wdata,         32'h12345678);
        end
        @(posedge clk); #1;
        chk("t2_mem_req_done", {31'b0, mem_req}, 32'h0);
      end
    join
    wait_st = 0;
    @(posedge clk); #1;

    // 3: simultaneous requests, data first, fetch 3 cycles later
    fork
      data_req(1'b0, 32'h200, 32'h0, rdv(32'h200), 2, 1'b0, 1'b0);
      fetch_req(32'h300, rdv(32'h300), 5);
    join
    @(posedge clk); #1;

    // 4: data held with fetch pending: 4 data, 1 fetch, data resumes
    fork
      begin
        data_req(1'b0, 32'h1000, 32'h0, rdv(32'h1000), 2, 1'b1, 1'b0);
        data_req(1'b0, 32'h1004, 32'h0, rdv(32'h1004), 3, 1'b1, 1'b0);
        data_req(1'b0, 32'h1008, 32'h0, rdv(32'h1008), 3, 1'b1, 1'b0);
        data_req(1'b0, 32'h100C, 32'h0, rdv(32'h100C), 3, 1'b1, 1'b0);
        data_req(1'b0, 32'h1010, 32'h0, rdv(32'h1010), 6, 1'b1, 1'b0);
        data_req(1'b0, 32'h1014, 32'h0, rdv(32'h1014), 3, 1'b0, 1'b0);
      end
      fetch_req(32'h2000, rdv(32'h2000), 14);
    join
    @(posedge clk); #1;

    // 5: reset while waiting on mem_ack
    no_ack  = 1'b1;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h80;
    @(posedge clk); #1;
    chk("t5_mem_req_pre", {31'b0, mem_req}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    d_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reset_outputs("t5");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("t5_mem_req_idle", {31'b0, mem_req}, 32'h0);
      chk("t5_d_ready_idle", {31'b0, d_ready}, 32'h0);
    end
    no_ack = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
    // 6: ack never arrives, abort after TB_TIMEOUT cycles in DATA
    no_ack = 1'b1;
    data_req(1'b0, 32'h90, 32'h0, 32'h0, 1 + TB_TIMEOUT, 1'b0, 1'b1);
    no_ack = 1'b0;
    @(posedge clk); #1;
    chk("t6_mem_req_after", {31'b0, mem_req}, 32'h0);
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("sb_d_empty",  32'(q_d.size()),  32'h0);
    chk("sb_if_empty", 32'(q_if.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
